// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage with integrated IF/ID pipeline register.
//   Owns the program counter, fetches over a req/ack handshake that tolerates
//   any number of wait states, holds one word in a skid buffer while decode
//   freezes, and redirects on taken branches from execute.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   freeze         decode hazard: IF/ID register must hold
//   branch_taken   single-cycle redirect request
//   branch_addr    redirect target (bits [1:0] forced to 0)
//   imem_req       fetch request (0 in HOLD and during reset)
//   imem_addr      fetch address (= pc)
//   imem_ack       memory returns data this cycle
//   imem_rdata     instruction word, valid with imem_ack
//   Instruction    IF/ID instruction
//   PC             IF/ID PC+4 of that instruction
//   valid          IF/ID contents are a real instruction
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        valid
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pc_tgt, w_pc_tgt_nxt;      // redirect target parked during DRAIN
    logic [31:0] r_buf_instr, w_buf_instr_nxt;
    logic [31:0] r_buf_pc, w_buf_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc_out, w_pc_out_nxt;
    logic        r_valid, w_valid_nxt;

    logic        w_req;
    logic        w_ack;
    logic [31:0] w_pc_inc;
    logic [31:0] w_br_tgt;

    // Request drops combinationally while reset is held so an in-flight
    // handshake is abandoned immediately.
    assign w_req    = rst && (r_state != HOLD);
    assign w_ack    = imem_ack && w_req;
    assign w_pc_inc = r_pc + 32'd4;           // wraps modulo 2^32
    assign w_br_tgt = branch_addr & ~32'h3;

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign Instruction = r_instr;
    assign PC          = r_pc_out;
    assign valid       = r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_pc_tgt    <= RESET_PC;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
            r_instr     <= '0;
            r_pc_out    <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pc_tgt    <= w_pc_tgt_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_pc_out    <= w_pc_out_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    // The skid buffer is only read on the HOLD -> FETCH release path, so a
    // branch "discards" it simply by leaving HOLD without consuming it.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pc_tgt_nxt    = r_pc_tgt;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;
        w_instr_nxt     = r_instr;
        w_pc_out_nxt    = r_pc_out;
        w_valid_nxt     = r_valid;

        case (r_state)
            FETCH: begin
                if (branch_taken) begin
                    w_valid_nxt = 1'b0;
                    if (w_ack) begin
                        w_pc_nxt = w_br_tgt;
                    end else begin
                        // Stale fetch still outstanding: finish it first.
                        w_pc_tgt_nxt = w_br_tgt;
                        w_state_nxt  = DRAIN;
                    end
                end else if (w_ack && !freeze) begin
                    w_instr_nxt  = imem_rdata;
                    w_pc_out_nxt = w_pc_inc;
                    w_valid_nxt  = 1'b1;
                    w_pc_nxt     = w_pc_inc;
                end else if (w_ack) begin
                    w_buf_instr_nxt = imem_rdata;
                    w_buf_pc_nxt    = w_pc_inc;
                    w_pc_nxt        = w_pc_inc;
                    w_state_nxt     = HOLD;
                end else if (!freeze) begin
                    w_valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = w_br_tgt;
                    w_state_nxt = FETCH;
                end else if (!freeze) begin
                    w_instr_nxt  = r_buf_instr;
                    w_pc_out_nxt = r_buf_pc;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = FETCH;
                end
            end
            DRAIN: begin
                w_valid_nxt = 1'b0;
                if (branch_taken) w_pc_tgt_nxt = w_br_tgt;
                if (w_ack) begin
                    // Returned data is dropped; newest target wins.
                    w_pc_nxt    = branch_taken ? w_br_tgt : r_pc_tgt;
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        valid;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Zero-latency memory contents; ack timing is driven by the tests.
    assign imem_rdata = mem_word(imem_addr);

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Instruction(Instruction), .PC(PC), .valid(valid)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        branch_addr = '0; imem_ack = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        if ({imem_req, imem_addr} !== {1'b0, 32'h100}) begin
            miscompares++;
            $display("FAIL reset_req_addr: got req=%b addr=%h want req=0 addr=00000100", imem_req, imem_addr);
        end
        vectors++;
        if ({valid, Instruction, PC} !== {1'b0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b I=%h PC=%h want 0/0/0", valid, Instruction, PC);
        end
        vectors++;
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({imem_req, imem_addr} !== {1'b1, 32'h100 + 32'(4 * i)}) begin
                miscompares++;
                $display("FAIL reset_seq_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 32'h100 + 32'(4 * i));
            end
            vectors++;
            if (i == 0) begin
                if (valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_first_valid: got %b want 0", valid);
                end
                vectors++;
            end else begin
                if ({valid, Instruction, PC} !== {1'b1, mem_word(32'h100 + 32'(4 * (i - 1))), 32'h100 + 32'(4 * i)}) begin
                    miscompares++;
                    $display("FAIL reset_seq_out[%0d]: got v=%b I=%h PC=%h want v=1 I=%h PC=%h", i, valid, Instruction, PC, mem_word(32'h100 + 32'(4 * (i - 1))), 32'h100 + 32'(4 * i));
                end
                vectors++;
            end
            next_cycle();
        end
        // Reset asserted mid-cycle must drop the request at once.
        #2;
        rst = 1'b0;
        #1;
        if ({imem_req, imem_addr, valid} !== {1'b0, 32'h100, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async: got req=%b addr=%h v=%b want req=0 addr=00000100 v=0", imem_req, imem_addr, valid);
        end
        vectors++;
        next_cycle();
        rst = 1'b1;
        imem_ack = 1'b0;
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_addr;
        logic [31:0] prev_addr;
        logic        prev_ack;
        apply_reset();
        exp_addr = 32'h100; prev_addr = '0; prev_ack = 1'b0;
        for (int k = 0; k < 9; k++) begin
            imem_ack = (k % 3 == 2);
            @(negedge clk);
            if ({imem_req, imem_addr} !== {1'b1, exp_addr}) begin
                miscompares++;
                $display("FAIL wait_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, exp_addr);
            end
            vectors++;
            if (valid !== prev_ack) begin
                miscompares++;
                $display("FAIL wait_valid[%0d]: got %b want %b", k, valid, prev_ack);
            end
            vectors++;
            if (prev_ack && {Instruction, PC} !== {mem_word(prev_addr), prev_addr + 32'd4}) begin
                miscompares++;
                $display("FAIL wait_data[%0d]: got I=%h PC=%h want I=%h PC=%h", k, Instruction, PC, mem_word(prev_addr), prev_addr + 32'd4);
            end
            if (prev_ack) vectors++;
            prev_ack = imem_ack;
            prev_addr = exp_addr;
            if (imem_ack) exp_addr = exp_addr + 32'd4;
            next_cycle();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_freeze();
        apply_reset();
        imem_ack = 1'b1;
        next_cycle();                     // cycle 0: fetch 0x100
        next_cycle();                     // cycle 1: fetch 0x104
        freeze = 1'b1;                    // cycle 2: fetch 0x108 into buffer
        @(negedge clk);
        if ({imem_req, imem_addr} !== {1'b1, 32'h108}) begin
            miscompares++;
            $display("FAIL freeze_capture_addr: got req=%b addr=%h want req=1 addr=00000108", imem_req, imem_addr);
        end
        vectors++;
        next_cycle();
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            if (imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze_req_low[%0d]: got %b want 0", c, imem_req);
            end
            vectors++;
            if ({valid, Instruction, PC} !== {1'b1, mem_word(32'h104), 32'h108}) begin
                miscompares++;
                $display("FAIL freeze_hold_out[%0d]: got v=%b I=%h PC=%h want v=1 I=%h PC=00000108", c, valid, Instruction, PC, mem_word(32'h104));
            end
            vectors++;
            next_cycle();
        end
        freeze = 1'b0;                    // cycle 6: release
        next_cycle();
        @(negedge clk);                   // cycle 7: buffered word out, fetch resumes
        if ({valid, Instruction, PC} !== {1'b1, mem_word(32'h108), 32'h10C}) begin
            miscompares++;
            $display("FAIL freeze_release_out: got v=%b I=%h PC=%h want v=1 I=%h PC=0000010c", valid, Instruction, PC, mem_word(32'h108));
        end
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10C}) begin
            miscompares++;
            $display("FAIL freeze_release_addr: got req=%b addr=%h want req=1 addr=0000010c", imem_req, imem_addr);
        end
        vectors++;
        next_cycle();
        @(negedge clk);                   // cycle 8
        if ({valid, Instruction, PC, imem_addr} !== {1'b1, mem_word(32'h10C), 32'h110, 32'h110}) begin
            miscompares++;
            $display("FAIL freeze_continue: got v=%b I=%h PC=%h addr=%h want v=1 I=%h PC=00000110 addr=00000110", valid, Instruction, PC, imem_addr, mem_word(32'h10C));
        end
        vectors++;
        next_cycle();
        imem_ack = 1'b0;
    endtask

    task automatic test_branch_zero_wait();
        apply_reset();
        imem_ack = 1'b1;
        next_cycle();                     // cycle 0
        branch_taken = 1'b1;              // cycle t
        branch_addr = 32'h203;
        next_cycle();
        branch_taken = 1'b0;
        branch_addr = '0;
        @(negedge clk);                   // t+1
        if ({imem_addr, valid} !== {32'h200, 1'b0}) begin
            miscompares++;
            $display("FAIL branch_zw_t1: got addr=%h v=%b want addr=00000200 v=0", imem_addr, valid);
        end
        vectors++;
        next_cycle();
        @(negedge clk);                   // t+2
        if ({valid, Instruction, PC} !== {1'b1, mem_word(32'h200), 32'h204}) begin
            miscompares++;
            $display("FAIL branch_zw_t2: got v=%b I=%h PC=%h want v=1 I=%h PC=00000204", valid, Instruction, PC, mem_word(32'h200));
        end
        vectors++;
        next_cycle();
        imem_ack = 1'b0;
    endtask

    task automatic test_branch_during_wait();
        apply_reset();
        imem_ack = 1'b1;
        branch_taken = 1'b1; branch_addr = 32'h40;   // get pc to 0x40
        next_cycle();
        imem_ack = 1'b0; branch_addr = 32'h400;      // fetch of 0x40 pending
        @(negedge clk);
        if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
            miscompares++;
            $display("FAIL bwait_c1_addr: got req=%b addr=%h want req=1 addr=00000040", imem_req, imem_addr);
        end
        vectors++;
        next_cycle();
        branch_addr = 32'h800;                        // second branch before ack
        @(negedge clk);
        if ({imem_req, imem_addr, valid} !== {1'b1, 32'h40, 1'b0}) begin
            miscompares++;
            $display("FAIL bwait_c2: got req=%b addr=%h v=%b want req=1 addr=00000040 v=0", imem_req, imem_addr, valid);
        end
        vectors++;
        next_cycle();
        branch_taken = 1'b0; branch_addr = '0; imem_ack = 1'b1;   // stale ack
        @(negedge clk);
        if ({imem_req, imem_addr, valid} !== {1'b1, 32'h40, 1'b0}) begin
            miscompares++;
            $display("FAIL bwait_c3: got req=%b addr=%h v=%b want req=1 addr=00000040 v=0", imem_req, imem_addr, valid);
        end
        vectors++;
        next_cycle();
        @(negedge clk);
        if ({imem_req, imem_addr, valid} !== {1'b1, 32'h800, 1'b0}) begin
            miscompares++;
            $display("FAIL bwait_redirect: got req=%b addr=%h v=%b want req=1 addr=00000800 v=0", imem_req, imem_addr, valid);
        end
        vectors++;
        next_cycle();
        @(negedge clk);
        if ({valid, Instruction, PC} !== {1'b1, mem_word(32'h800), 32'h804}) begin
            miscompares++;
            $display("FAIL bwait_target_out: got v=%b I=%h PC=%h want v=1 I=%h PC=00000804", valid, Instruction, PC, mem_word(32'h800));
        end
        vectors++;
        next_cycle();
        imem_ack = 1'b0;
    endtask

    task automatic test_hold_branch_wrap();
        apply_reset();
        imem_ack = 1'b1;
        next_cycle();                     // cycle 0: 0x100
        freeze = 1'b1;                    // cycle 1: 0x104 buffered
        next_cycle();
        branch_taken = 1'b1;              // cycle 2: HOLD, branch
        branch_addr = 32'hFFFF_FFFE;
        @(negedge clk);
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_br_req: got %b want 0", imem_req);
        end
        vectors++;
        next_cycle();
        branch_taken = 1'b0; branch_addr = '0; freeze = 1'b0;
        @(negedge clk);                   // cycle 3
        if ({imem_req, imem_addr, valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
            miscompares++;
            $display("FAIL hold_br_target: got req=%b addr=%h v=%b want req=1 addr=fffffffc v=0", imem_req, imem_addr, valid);
        end
        vectors++;
        next_cycle();
        @(negedge clk);                   // cycle 4
        if ({valid, Instruction, PC, imem_addr} !== {1'b1, mem_word(32'hFFFF_FFFC), 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL pc_wrap: got v=%b I=%h PC=%h addr=%h want v=1 I=%h PC=0 addr=0", valid, Instruction, PC, imem_addr, mem_word(32'hFFFF_FFFC));
        end
        vectors++;
        next_cycle();
        @(negedge clk);                   // cycle 5
        if ({valid, Instruction, PC} !== {1'b1, mem_word(32'h0), 32'h4}) begin
            miscompares++;
            $display("FAIL pc_wrap_next: got v=%b I=%h PC=%h want v=1 I=%h PC=4", valid, Instruction, PC, mem_word(32'h0));
        end
        vectors++;
        next_cycle();
        imem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        branch_addr = '0; imem_ack = 1'b0;
        #1;
        test_reset();
        test_wait_states();
        test_freeze();
        test_branch_zero_wait();
        test_branch_during_wait();
        test_hold_branch_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
